// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives a req/gnt/rvalid instruction memory port and fills the IF/ID register.
// One request is outstanding at most; a skid register absorbs a response that arrives while decode is stalled.
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Br_taken,
    input  logic [31:0] Br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        req_q;
    logic [31:0] pc_plus4;
    logic        can_accept;

    assign pc_plus4   = fetch_pc_q + 32'd4;
    assign can_accept = !valid_q || !freeze;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;

        // Decode consumed the current word; it becomes a bubble unless a new word lands below.
        if (!freeze) begin
            valid_d = 1'b0;
        end

        if (Br_taken) begin
            fetch_pc_d = {Br_addr[31:2], 2'b00};
            valid_d    = 1'b0;
            case (state_q)
                REQ: begin
                    if (imem_gnt) begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else if (can_accept) begin
                            instr_d    = imem_rdata;
                            pc_d       = pc_plus4;
                            valid_d    = 1'b1;
                            fetch_pc_d = pc_plus4;
                            state_d    = REQ;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_plus4;
                            fetch_pc_d   = pc_plus4;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        instr_d = skid_instr_q;
                        pc_d    = skid_pc_q;
                        valid_d = 1'b1;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The request strobe is registered from the next state so it is glitch-free at the memory port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= 32'd0;
            kill_q       <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            instr_q      <= 32'd0;
            pc_q         <= 32'd0;
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            req_q        <= (state_d == REQ);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign Instruction = instr_q;
    assign PC          = pc_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a randomized memory responder plus a stream-level reference model
// (requests and delivered words must follow program order, restarting at each branch target).
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        valid;

    int          testCount;
    int          failCount;
    int          deliveries;
    int          latLeft;
    int          maxLat;
    logic        outstanding;
    logic [31:0] outAddr;
    logic [31:0] expReqAddr;
    logic [31:0] expDelAddr;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .Br_taken    (Br_taken),
        .Br_addr     (Br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .PC          (PC),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents; address 0 holds 0x20010005.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h2001_0005;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        outstanding = 1'b0;
        latLeft     = 0;
        outAddr     = 32'd0;
        expReqAddr  = 32'd0;
        expDelAddr  = 32'd0;
    endtask

    // Called just after a falling edge: drives one cycle of inputs, advances the model across
    // the rising edge, then checks the IF/ID outputs at the next falling edge.
    task automatic applyStimulus(input logic fr, input logic br, input logic [31:0] ba, input logic gn);
        logic        hs;
        logic        realRv;
        logic        prevValid;
        logic [31:0] prevInstr;
        logic [31:0] prevPc;
        logic        newDel;

        realRv = 1'b0;
        if (outstanding) begin
            checkOutput("reqWhileBusy", {31'b0, imem_req}, 32'd0);
            if (latLeft == 0) begin
                realRv      = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(outAddr);
            end else begin
                latLeft--;
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end else begin
            imem_rvalid = ($urandom_range(0, 9) == 0);
            imem_rdata  = $urandom;
        end
        freeze   = fr;
        Br_taken = br;
        Br_addr  = ba;
        imem_gnt = gn;

        hs = imem_req && gn;
        if (hs) begin
            checkOutput("reqAddr", imem_addr, expReqAddr);
        end
        if (realRv) begin
            outstanding = 1'b0;
        end
        if (hs) begin
            outstanding = 1'b1;
            outAddr     = expReqAddr;
            latLeft     = $urandom_range(0, maxLat);
        end
        if (br) begin
            expReqAddr = {ba[31:2], 2'b00};
            expDelAddr = {ba[31:2], 2'b00};
        end else if (hs) begin
            expReqAddr = expReqAddr + 32'd4;
        end

        prevValid = valid;
        prevInstr = Instruction;
        prevPc    = PC;

        @(negedge clk);

        if (br) begin
            checkOutput("flushValid", {31'b0, valid}, 32'd0);
        end
        newDel = valid && !br && (!fr || !prevValid);
        if (newDel) begin
            checkOutput("instr", Instruction, memWord(expDelAddr));
            checkOutput("pc", PC, expDelAddr + 32'd4);
            expDelAddr = expDelAddr + 32'd4;
            deliveries++;
        end else begin
            checkOutput("instrHold", Instruction, prevInstr);
            checkOutput("pcHold", PC, prevPc);
            if (fr && prevValid && !br) begin
                checkOutput("validHold", {31'b0, valid}, 32'd1);
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Req"}, {31'b0, imem_req}, 32'd0);
        checkOutput({tag, "Addr"}, imem_addr, 32'd0);
        checkOutput({tag, "Instr"}, Instruction, 32'd0);
        checkOutput({tag, "Pc"}, PC, 32'd0);
        checkOutput({tag, "Valid"}, {31'b0, valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time %0t reached, expected $finish well before", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          startDel;
        logic        fr;
        logic        br;
        logic        gn;
        logic [31:0] ba;

        testCount   = 0;
        failCount   = 0;
        deliveries  = 0;
        maxLat      = 0;
        rst         = 1'b0;
        freeze      = 1'b0;
        Br_taken    = 1'b0;
        Br_addr     = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        resetModel();

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;

        // Back-to-back fetch with an always-granting, single-cycle memory.
        repeat (8) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("firstRuns", {31'b0, deliveries >= 2}, 32'd1);

        // Grant withheld: request must stay up with a stable address.
        for (int i = 0; i < 8 && !imem_req; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("stallReq", {31'b0, imem_req}, 32'd1);
        checkOutput("stallAddr", imem_addr, expReqAddr);
        checkOutput("stallBubble", {31'b0, valid}, 32'd0);

        // Response arrives while decode is frozen on a live word.
        for (int i = 0; i < 10 && !valid; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("holdNoReq", {31'b0, imem_req}, 32'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect while a response is in flight; low address bits must be dropped.
        maxLat = 2;
        for (int i = 0; i < 10 && !outstanding; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        for (int i = 0; i < 10 && !imem_req; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("brTarget", imem_addr, 32'h0000_0100);

        // Fetch address wraps from the top of memory to zero.
        maxLat = 0;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 12 && !valid; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("wrapPc", PC, 32'h0000_0000);
        checkOutput("wrapReq", {31'b0, imem_req}, 32'd1);
        checkOutput("wrapAddr", imem_addr, 32'h0000_0000);

        // Asynchronous reset between clock edges while waiting on memory.
        maxLat = 2;
        for (int i = 0; i < 10 && !outstanding; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        #2 rst = 1'b0;
        #1 checkAllZero("asyncRst");
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        resetModel();
        for (int i = 0; i < 10 && !imem_req; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("postRstAddr", imem_addr, 32'h0000_0000);

        // Randomized traffic: stalls, redirects (some near the wrap point), grant gaps, latency.
        startDel = deliveries;
        for (int i = 0; i < 3000; i++) begin
            fr = ($urandom_range(0, 9) < 3);
            br = ($urandom_range(0, 99) < 8);
            gn = ($urandom_range(0, 9) < 7);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(fr, br, ba, gn);
        end
        checkOutput("progress", {31'b0, (deliveries - startDel) > 100}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-003: freeze  input  1  hazard stall from decode; hold the IF/ID outputs.
REQ-004: Br_taken  input  1  branch redirect from decode; flush and refetch.
REQ-005: Br_addr  input  32  redirect byte address; bits [1:0] ignored, treated as 00.
REQ-006: imem_req  output  1  fetch request to instruction memory.
REQ-007: imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-008: imem_gnt  input  1  memory accepted the request this cycle (req&gnt = handshake).
REQ-009: imem_rvalid  input  1  read data valid this cycle.
REQ-010: imem_rdata  input  32  fetched instruction word.
REQ-011: Instruction  output  32  IF/ID instruction register.
REQ-012: PC  output  32  IF/ID register holding fetch address + 4 of Instruction.
REQ-013: valid  output  1  IF/ID contents are a live instruction.

Function
REQ-014: FSM states: IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-015: IDLE: imem_req=0; next state REQ unconditionally.
REQ-016: REQ: imem_req=1, imem_addr=fetch_pc; gnt=1 -> WAIT; gnt=0 -> stay REQ (address may change only on redirect).
REQ-017: REQ is entered only when the IF/ID register can accept (valid=0 or freeze=0); otherwise FSM stays in HOLD/WAIT; imem_req never asserted in IDLE, WAIT, HOLD.
REQ-018: WAIT, rvalid=1, kill=0, IF/ID free (valid=0 or freeze=0): Instruction<=imem_rdata, PC<=fetch_pc+4, valid<=1, fetch_pc<=fetch_pc+4, -> REQ.
REQ-019: WAIT, rvalid=1, kill=0, freeze=1 and valid=1: word and fetch_pc+4 captured in skid register, fetch_pc<=fetch_pc+4, -> HOLD.
REQ-020: WAIT, rvalid=1, kill=1: data discarded, kill<=0, -> REQ at redirected fetch_pc.
REQ-021: HOLD: freeze=0 -> skid transferred to IF/ID (valid<=1), -> REQ; freeze=1 -> stay, outputs unchanged.
REQ-022: freeze=1 with no redirect: Instruction, PC, valid unchanged.
REQ-023: no-freeze case: freeze=0 with no new word -> valid<=0 (bubble); Instruction/PC hold last value.
REQ-024: Br_taken=1 (any state, priority over freeze and rvalid): fetch_pc<={Br_addr[31:2],2'b00}, valid<=0, skid discarded.
REQ-025: Br_taken in WAIT (or REQ with gnt=1 same cycle): kill<=1, state WAIT; rvalid in that same cycle also discarded, -> REQ.
REQ-026: Br_taken in REQ with gnt=0: stay REQ, imem_addr takes new address next cycle; in HOLD or IDLE: -> REQ.
REQ-027: fetch_pc arithmetic modulo 2^32: 0xFFFFFFFC+4 = 0x00000000; PC output likewise wraps.
REQ-028: rvalid outside WAIT ignored.
REQ-029: best-case throughput one instruction per 2 cycles; latency req-accept to valid = rvalid cycle + 1.

Reset
REQ-030: rst=0: state IDLE, fetch_pc=0, kill=0, skid empty, Instruction=0, PC=0, valid=0, imem_req=0, imem_addr=0.
REQ-031: rst asserted mid-request: in-flight response discarded; after release first request is to address 0x00000000.

Verification
REQ-032: reset release, gnt=1 always, rvalid 1 cycle after gnt, rdata=0x20010005 -> imem_addr 0x0,0x4,0x8...; first Instruction=0x20010005, PC=0x4, valid=1.
REQ-033: gnt held 0 for 3 cycles -> imem_req stays 1, imem_addr stable 0x0, valid=0, no fetch_pc advance.
REQ-034: freeze=1 while valid=1 and response 0xAAAA0000 arrives -> outputs unchanged, HOLD; freeze=0 -> Instruction=0xAAAA0000 next edge.
REQ-035: Br_taken=1, Br_addr=0x00000103 in WAIT -> pending rvalid discarded, valid=0, next imem_addr=0x00000100.
REQ-036: fetch_pc=0xFFFFFFFC, response returned -> PC=0x00000000, next imem_addr=0x00000000.
REQ-037: rst=0 pulse asynchronous (between edges) during WAIT -> all outputs zero immediately; first post-reset request to 0x0.
